pid_chan_sched: RTL and testbench

//   Time-multiplexes one shared pid_core across N_CHAN input channels. Latches one pending

---
 rtl/pid_chan_sched_if.sv | 27 ++
 rtl/pid_chan_sched.sv | 190 +++++++++++++++++++
 tb/tb_pid_chan_sched.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/pid_chan_sched_if.sv
// Handshake bundle between the channel scheduler, the shared pid_core and the source mux.
interface pid_chan_sched_if #(
    parameter int W_IN   = 18,
    parameter int W_CHAN = 2,
    parameter int W_OUT  = 64
);
    logic [W_IN-1:0]   pid_data_out;
    logic              pid_valid_out;
    logic [W_CHAN-1:0] pid_chan_out;
    logic [W_OUT-1:0]  pid_data_in;
    logic              pid_valid_in;
    logic [W_OUT-1:0]  data_out;
    logic [W_CHAN-1:0] chan_out;
    logic              data_valid_out;

    modport master (
        output pid_data_out, pid_valid_out, pid_chan_out,
        input  pid_data_in, pid_valid_in,
        output data_out, chan_out, data_valid_out
    );

    modport slave (
        input  pid_data_out, pid_valid_out, pid_chan_out,
        output pid_data_in, pid_valid_in,
        input  data_out, chan_out, data_valid_out
    );
endinterface

// File: rtl/pid_chan_sched.sv
// Round-robin time-multiplexer of one pid_core across N_CHAN channels, with a
// one-deep pending slot per channel and sticky overrun / core-timeout status.
module pid_chan_slot #(
    parameter int W_IN = 18
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            strobe_i,
    input  logic            en_i,
    input  logic            grant_i,
    input  logic            clear_i,
    input  logic [W_IN-1:0] data_i,
    output logic            pend_o,
    output logic            ovr_o,
    output logic [W_IN-1:0] data_o
);
    logic            pend_q, pend_d;
    logic            ovr_q, ovr_d;
    logic [W_IN-1:0] data_q;

    // A strobe always leaves the slot pending, even against grant or clear.
    always_comb begin
        pend_d = pend_q;
        ovr_d  = ovr_q;
        if (grant_i || clear_i || !en_i) pend_d = 1'b0;
        if (strobe_i && pend_q && !grant_i) ovr_d = 1'b1;
        if (clear_i) ovr_d = 1'b0;
        if (strobe_i) pend_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q <= 1'b0;
            ovr_q  <= 1'b0;
            data_q <= '0;
        end else begin
            pend_q <= pend_d;
            ovr_q  <= ovr_d;
            if (strobe_i) data_q <= data_i;
        end
    end

    assign pend_o = pend_q;
    assign ovr_o  = ovr_q;
    assign data_o = data_q;
endmodule

module pid_chan_sched #(
    parameter int N_CHAN  = 4,
    parameter int W_CHAN  = 2,
    parameter int W_IN    = 18,
    parameter int W_OUT   = 64,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk_in,
    input  logic                   reset_in,
    input  logic [N_CHAN*W_IN-1:0] data_in,
    input  logic [N_CHAN-1:0]      data_valid_in,
    input  logic [N_CHAN-1:0]      chan_en_in,
    input  logic                   clear_in,
    pid_chan_sched_if.master       bus,
    output logic [N_CHAN-1:0]      overrun_out,
    output logic                   timeout_out,
    output logic                   busy_out
);
    localparam int W_CNT = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_SEND  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [W_CHAN-1:0] rr_q, rr_d;
    logic [W_IN-1:0]   pid_data_q, pid_data_d;
    logic [W_CHAN-1:0] pid_chan_q, pid_chan_d;
    logic [W_CNT-1:0]  cnt_q, cnt_d;
    logic [W_OUT-1:0]  res_q, res_d;
    logic [W_CHAN-1:0] res_chan_q, res_chan_d;
    logic              timeout_q, timeout_d;

    logic [N_CHAN-1:0]           pend, req, grant;
    logic [N_CHAN-1:0][W_IN-1:0] slot_data;
    logic                        any_req;
    logic [W_CHAN-1:0]           sel;

    for (genvar k = 0; k < N_CHAN; k++) begin : g_slot
        pid_chan_slot #(.W_IN(W_IN)) u_slot (
            .clk_i    (clk_in),
            .rst_i    (reset_in),
            .strobe_i (data_valid_in[k] & chan_en_in[k]),
            .en_i     (chan_en_in[k]),
            .grant_i  (grant[k]),
            .clear_i  (clear_in),
            .data_i   (data_in[k*W_IN +: W_IN]),
            .pend_o   (pend[k]),
            .ovr_o    (overrun_out[k]),
            .data_o   (slot_data[k])
        );
    end

    assign req = pend & chan_en_in;

    // Search starts just after the last served channel; rr itself is checked last.
    always_comb begin
        any_req = 1'b0;
        sel     = rr_q;
        for (int i = 1; i <= N_CHAN; i++) begin
            if (!any_req && req[(int'(rr_q) + i) % N_CHAN]) begin
                any_req = 1'b1;
                sel     = W_CHAN'((int'(rr_q) + i) % N_CHAN);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        pid_data_d = pid_data_q;
        pid_chan_d = pid_chan_q;
        cnt_d      = cnt_q;
        res_d      = res_q;
        res_chan_d = res_chan_q;
        timeout_d  = timeout_q;
        grant      = '0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    grant[sel] = 1'b1;
                    pid_data_d = slot_data[sel];
                    pid_chan_d = sel;
                    rr_d       = sel;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.pid_valid_in) begin
                    res_d      = bus.pid_data_in;
                    res_chan_d = pid_chan_q;
                    state_d    = ST_SEND;
                end else if (cnt_q == W_CNT'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SEND: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (clear_in) timeout_d = 1'b0;
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q    <= ST_IDLE;
            rr_q       <= '0;
            pid_data_q <= '0;
            pid_chan_q <= '0;
            cnt_q      <= '0;
            res_q      <= '0;
            res_chan_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            pid_data_q <= pid_data_d;
            pid_chan_q <= pid_chan_d;
            cnt_q      <= cnt_d;
            res_q      <= res_d;
            res_chan_q <= res_chan_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.pid_data_out   = pid_data_q;
    assign bus.pid_chan_out   = pid_chan_q;
    assign bus.pid_valid_out  = (state_q == ST_ISSUE);
    assign bus.data_out       = res_q;
    assign bus.chan_out       = res_chan_q;
    assign bus.data_valid_out = (state_q == ST_SEND);
    assign timeout_out        = timeout_q;
    assign busy_out           = (state_q != ST_IDLE);
endmodule

// File: tb/tb_pid_chan_sched.sv
// Directed bench for pid_chan_sched: hand-computed issue order, latency, overrun,
// timeout, channel-disable and reset-abort behaviour.
module tb_pid_chan_sched;
    logic        clk = 1'b0;
    logic        reset_in;
    logic [71:0] data_in;
    logic [3:0]  data_valid_in;
    logic [3:0]  chan_en_in;
    logic        clear_in;
    logic [3:0]  overrun_out;
    logic        timeout_out;
    logic        busy_out;

    int nvec  = 0;
    int nfail = 0;

    pid_chan_sched_if #(.W_IN(18), .W_CHAN(2), .W_OUT(64)) bus ();

    pid_chan_sched #(
        .N_CHAN(4), .W_CHAN(2), .W_IN(18), .W_OUT(64), .TIMEOUT(16)
    ) dut (
        .clk_in        (clk),
        .reset_in      (reset_in),
        .data_in       (data_in),
        .data_valid_in (data_valid_in),
        .chan_en_in    (chan_en_in),
        .clear_in      (clear_in),
        .bus           (bus),
        .overrun_out   (overrun_out),
        .timeout_out   (timeout_out),
        .busy_out      (busy_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic [3:0] mask, input logic [17:0] d0, input logic [17:0] d1,
                          input logic [17:0] d2, input logic [17:0] d3);
        data_in       = {d3, d2, d1, d0};
        data_valid_in = mask;
        tick();
        data_valid_in = 4'b0;
    endtask

    // Waits (bounded) for the issue strobe, checks it, answers after one WAIT cycle,
    // checks the tagged result, and returns to IDLE.
    task automatic serve(input string tag, input logic [1:0] ch, input logic [17:0] smp,
                         input logic [63:0] res);
        int n = 0;
        while (!bus.pid_valid_out && n < 8) begin
            tick();
            n++;
        end
        chk({tag, " issue"}, bus.pid_valid_out, 1);
        chk({tag, " pid_chan"}, bus.pid_chan_out, ch);
        chk({tag, " pid_data"}, bus.pid_data_out, smp);
        tick();
        bus.pid_valid_in = 1'b1;
        bus.pid_data_in  = res;
        tick();
        bus.pid_valid_in = 1'b0;
        chk({tag, " dvalid"}, bus.data_valid_out, 1);
        chk({tag, " chan_out"}, bus.chan_out, ch);
        chk({tag, " data_out"}, bus.data_out, res);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_in         = 1'b1;
        data_in          = '0;
        data_valid_in    = '0;
        chan_en_in       = 4'hF;
        clear_in         = 1'b0;
        bus.pid_data_in  = '0;
        bus.pid_valid_in = 1'b0;
        tick();
        tick();
        chk("rst pid_valid", bus.pid_valid_out, 0);
        chk("rst dvalid", bus.data_valid_out, 0);
        chk("rst busy", busy_out, 0);
        chk("rst overrun", overrun_out, 0);
        chk("rst timeout", timeout_out, 0);
        chk("rst data_out", bus.data_out, 0);
        reset_in = 1'b0;
        tick();

        // T1: ch0 alone, core answers 2 cycles after issue
        strobe(4'b0001, 18'h00100, 18'h0, 18'h0, 18'h0);
        chk("t1 idle busy", busy_out, 0);
        tick();
        chk("t1 pid_valid", bus.pid_valid_out, 1);
        chk("t1 pid_data", bus.pid_data_out, 18'h00100);
        chk("t1 pid_chan", bus.pid_chan_out, 0);
        chk("t1 busy", busy_out, 1);
        tick();
        chk("t1 pid_valid one-shot", bus.pid_valid_out, 0);
        tick();
        bus.pid_valid_in = 1'b1;
        bus.pid_data_in  = 64'd7;
        tick();
        bus.pid_valid_in = 1'b0;
        chk("t1 dvalid", bus.data_valid_out, 1);
        chk("t1 data_out", bus.data_out, 64'd7);
        chk("t1 chan_out", bus.chan_out, 0);
        tick();
        chk("t1 dvalid one-shot", bus.data_valid_out, 0);
        chk("t1 data hold", bus.data_out, 64'd7);

        // T2: all four pending with rr=0 -> 1,2,3,0
        strobe(4'b1111, 18'h10, 18'h11, 18'h12, 18'h13);
        serve("t2 c1", 2'd1, 18'h11, 64'h101);
        serve("t2 c2", 2'd2, 18'h12, 64'h102);
        serve("t2 c3", 2'd3, 18'h13, 64'h103);
        serve("t2 c0", 2'd0, 18'h10, 64'h100);
        chk("t2 overrun", overrun_out, 4'b0000);

        // T3: ch2 overwritten while ch1 is in flight
        strobe(4'b0010, 18'h0, 18'h21, 18'h0, 18'h0);
        tick();
        chk("t3 issue c1", bus.pid_valid_out, 1);
        strobe(4'b0100, 18'h0, 18'h0, 18'd5, 18'h0);
        strobe(4'b0100, 18'h0, 18'h0, 18'd9, 18'h0);
        chk("t3 overrun set", overrun_out, 4'b0100);
        bus.pid_valid_in = 1'b1;
        bus.pid_data_in  = 64'h31;
        tick();
        bus.pid_valid_in = 1'b0;
        chk("t3 c1 chan_out", bus.chan_out, 1);
        chk("t3 c1 data_out", bus.data_out, 64'h31);
        tick();
        serve("t3 c2", 2'd2, 18'd9, 64'h32);
        chk("t3 overrun sticky", overrun_out, 4'b0100);
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        chk("t3 overrun cleared", overrun_out, 4'b0000);

        // T4: ch3 issued, core silent
        strobe(4'b1000, 18'h0, 18'h0, 18'h0, 18'h3AB);
        tick();
        chk("t4 issue", bus.pid_valid_out, 1);
        chk("t4 pid_chan", bus.pid_chan_out, 3);
        for (int i = 0; i < 16; i++) tick();
        chk("t4 no timeout yet", timeout_out, 0);
        chk("t4 still busy", busy_out, 1);
        tick();
        chk("t4 timeout", timeout_out, 1);
        chk("t4 idle", busy_out, 0);
        chk("t4 no dvalid", bus.data_valid_out, 0);
        tick();
        chk("t4 no dvalid late", bus.data_valid_out, 0);
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        chk("t4 timeout cleared", timeout_out, 0);

        // T5: ch2 disabled while pending; rr=3 -> 0,1,3
        strobe(4'b1111, 18'h40, 18'h41, 18'h42, 18'h43);
        chan_en_in = 4'b1011;
        serve("t5 c0", 2'd0, 18'h40, 64'h200);
        serve("t5 c1", 2'd1, 18'h41, 64'h201);
        serve("t5 c3", 2'd3, 18'h43, 64'h203);
        strobe(4'b0100, 18'h0, 18'h0, 18'h77, 18'h0);
        chan_en_in = 4'hF;
        tick();
        chk("t5 ch2 dropped", bus.pid_valid_out, 0);
        tick();
        chk("t5 ch2 dropped busy", busy_out, 0);

        // T6: reset in ST_WAIT, core answers afterwards
        strobe(4'b0010, 18'h0, 18'h55, 18'h0, 18'h0);
        tick();
        chk("t6 issue", bus.pid_valid_out, 1);
        tick();
        reset_in = 1'b1;
        tick();
        reset_in         = 1'b0;
        bus.pid_valid_in = 1'b1;
        bus.pid_data_in  = 64'hDEAD;
        tick();
        bus.pid_valid_in = 1'b0;
        chk("t6 no dvalid", bus.data_valid_out, 0);
        chk("t6 idle", busy_out, 0);
        chk("t6 data_out", bus.data_out, 0);
        chk("t6 pid_data", bus.pid_data_out, 0);
        tick();
        chk("t6 no dvalid late", bus.data_valid_out, 0);
        chk("t6 still idle", busy_out, 0);

        // Strobe on the channel being granted stays pending without overrun
        strobe(4'b0001, 18'hA, 18'h0, 18'h0, 18'h0);
        strobe(4'b0001, 18'hB, 18'h0, 18'h0, 18'h0);
        chk("t7 issue", bus.pid_valid_out, 1);
        chk("t7 pid_data old", bus.pid_data_out, 18'hA);
        chk("t7 no overrun", overrun_out, 4'b0000);
        tick();
        bus.pid_valid_in = 1'b1;
        bus.pid_data_in  = 64'h300;
        tick();
        bus.pid_valid_in = 1'b0;
        tick();
        serve("t7 repend", 2'd0, 18'hB, 64'h301);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
